// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the machine-mode interrupt controller:
//   irq_state_t     - trap sequencing state (IDLE, TAKE, HANDLER)
//   IRQ_MIE_BASE    - mie bit position of external line 0
//   MCAUSE_IRQ_BIT  - mcause bit flagging an interrupt (vs. exception)
//   irq_mcause()    - builds the mcause value for an external line index
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2
    } irq_state_t;

    localparam int unsigned IRQ_MIE_BASE   = 16;
    localparam int unsigned MCAUSE_IRQ_BIT = 31;

    // External line k reports cause code 16+k with the interrupt flag set.
    function automatic logic [31:0] irq_mcause(input logic [4:0] idx);
        logic [31:0] cause;
        cause                 = 32'(IRQ_MIE_BASE) + 32'(idx);
        cause[MCAUSE_IRQ_BIT] = 1'b1;
        return cause;
    endfunction

endpackage

// File: rtl/irq_priority_arbiter.sv
// -----------------------------------------------------------------------------
// irq_priority_arbiter
// Combinational lowest-index priority encoder.
// Ports:
//   req_i    in  NUM_IRQ  request vector
//   valid_o  out 1        at least one request set
//   index_o  out IDX_W    index of the lowest set request (0 when none)
// -----------------------------------------------------------------------------
module irq_priority_arbiter #(
    parameter int NUM_IRQ = 16,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   index_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the block leaves it unassigned (which infers a latch).
        valid_o = 1'b0;
        index_o = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Machine-mode interrupt controller. Latches rising edges on the external
// request lines, masks them with mie, picks the lowest eligible line and
// sequences trap entry (TAKE) and the handler window until mret.
// Ports:
//   clk_i        in  1        clock
//   rst_ni       in  1        asynchronous active-low reset
//   irq_req_i    in  NUM_IRQ  external requests, rising-edge sensitive
//   mie_i        in  32       interrupt enable CSR; line k is bit 16+k
//   exception_i  in  1        synchronous exception trapped this cycle
//   mret_i       in  1        mret retiring this cycle
//   stall_i      in  1        core stalled, interrupt entry deferred
//   irq_o        out 1        interrupt trap taken (one-cycle pulse)
//   trap_o       out 1        irq_o | exception_i, to CSR trap_i
//   irq_cause_o  out 32       mcause for the taken interrupt
//   irq_ack_o    out NUM_IRQ  one-hot acknowledge, with irq_o
//   in_trap_o    out 1        handler active (TAKE or HANDLER)
// -----------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [31:0]        mie_i,
    input  logic               exception_i,
    input  logic               mret_i,
    input  logic               stall_i,
    output logic               irq_o,
    output logic               trap_o,
    output logic [31:0]        irq_cause_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic               in_trap_o
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [31:0] MIE_USED =
        32'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_MIE_BASE);

    irq_state_t         state_q;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [IDX_W-1:0]   sel_q;
    logic [NUM_IRQ-1:0] eligible;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               mie_unused;

    // Only the mie bits that map to external lines matter here.
    assign mie_unused = ^(mie_i & ~MIE_USED);

    // -------------------------------------------------------------------------
    // Edge detection and pending latch. A new edge on a line being
    // acknowledged in the same cycle survives: set wins over clear.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            req_q     <= irq_req_i;
            pending_q <= (pending_q & ~irq_ack_o) | (irq_req_i & ~req_q);
        end
    end

    // Masking is applied only here, at the selection point; once in TAKE the
    // latched sel_q carries the trap through regardless of mie.
    assign eligible = pending_q & mie_i[IRQ_MIE_BASE +: NUM_IRQ];

    irq_priority_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .req_i   (eligible),
        .valid_o (win_valid),
        .index_o (win_idx)
    );

    // -------------------------------------------------------------------------
    // Trap sequencing FSM. An exception in IDLE pre-empts any interrupt and
    // leaves pending bits alone; exceptions inside the handler are not tracked.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exception_i) begin
                        state_q <= HANDLER;
                    end else if (win_valid && !stall_i) begin
                        state_q <= TAKE;
                        sel_q   <= win_idx;
                    end
                end
                TAKE:    state_q <= HANDLER;
                HANDLER: if (mret_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; exception_i into trap_o is the
    // single combinational input-to-output path.
    assign irq_o       = (state_q == TAKE);
    assign irq_ack_o   = irq_o ? (NUM_IRQ'(1) << sel_q) : '0;
    assign irq_cause_o = irq_o ? irq_mcause(5'(sel_q)) : '0;
    assign in_trap_o   = (state_q != IDLE);
    assign trap_o      = irq_o | exception_i;

endmodule
